// File: rtl/local_eject_sink.sv
// Ejection-side sink for a router LOCAL port: on/off-flow-controlled FIFO,
// packet reassembly with order/address/length checking, and saturating statistics.
module local_eject_sink #(
    parameter int FLIT_W     = 34,
    parameter int FIFO_DEPTH = 8,
    parameter int OFF_MARGIN = 2,
    parameter int MY_X       = 0,
    parameter int MY_Y       = 0,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [FLIT_W-1:0] i_flit,
    input  logic              i_upstream_req,
    output logic              o_on_off,
    input  logic              i_drain_en,
    output logic [CNT_W-1:0]  o_pkt_cnt,
    output logic [CNT_W-1:0]  o_flit_cnt,
    output logic [CNT_W-1:0]  o_err_cnt,
    output logic              o_overflow,
    output logic              o_busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] OFF_TH  = (AW+1)'(FIFO_DEPTH - 1 - OFF_MARGIN);
    localparam logic [3:0]  MX = 4'(MY_X);
    localparam logic [3:0]  MY = 4'(MY_Y);
    localparam logic [1:0]  T_HEAD = 2'b00, T_BODY = 2'b01, T_TAIL = 2'b10, T_HT = 2'b11;

    typedef enum logic {IDLE, BODY} state_t;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W+1)'(b);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    logic [FLIT_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count, count_n;
    logic              empty, full, push, pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign pop     = i_drain_en && !empty;
    // A pop frees the slot first, so a push into a full FIFO still lands.
    assign push    = i_upstream_req && (!full || pop);
    assign count_n = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= i_flit;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_on_off   <= 1'b1;
            o_overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count    <= count_n;
            o_on_off <= !(count_n > OFF_TH);
            if (i_upstream_req && !push) o_overflow <= 1'b1;
        end
    end

    // Reassembly on the flit leaving the FIFO head.
    logic [FLIT_W-1:0] hflit;
    logic [1:0]        ftype;
    logic [7:0]        hd_len;
    logic              hd_addr_ok;

    assign hflit      = mem[rd_ptr];
    assign ftype      = hflit[FLIT_W-1 -: 2];
    assign hd_len     = hflit[23:16];
    assign hd_addr_ok = (hflit[31:28] == MX) && (hflit[27:24] == MY);

    state_t     state, state_n;
    logic [7:0] len_q, len_n, flit_seen, seen_n, seen_inc;
    logic       addr_ok_q, addr_ok_n, start_new, pkt_add;
    logic [1:0] err_add;

    assign seen_inc = (flit_seen == 8'hFF) ? flit_seen : flit_seen + 8'd1;

    always_comb begin
        state_n   = state;
        len_n     = len_q;
        addr_ok_n = addr_ok_q;
        seen_n    = flit_seen;
        start_new = 1'b0;
        pkt_add   = 1'b0;
        err_add   = 2'd0;
        if (pop) begin
            case (state)
                IDLE: begin
                    if (ftype == T_HEAD || ftype == T_HT) start_new = 1'b1;
                    else                                  err_add   = 2'd1;
                end
                BODY: begin
                    case (ftype)
                        T_BODY: seen_n = seen_inc;
                        T_TAIL: begin
                            seen_n  = seen_inc;
                            state_n = IDLE;
                            // Short length fields fail here too: seen >= 2 at any tail.
                            if (addr_ok_q && seen_inc == len_q) pkt_add = 1'b1;
                            else                                err_add = 2'd1;
                        end
                        default: begin
                            err_add   = 2'd1;
                            start_new = 1'b1;
                        end
                    endcase
                end
                default: state_n = IDLE;
            endcase
            if (start_new) begin
                if (ftype == T_HT) begin
                    state_n = IDLE;
                    if (hd_addr_ok && hd_len == 8'd1) pkt_add = 1'b1;
                    else                              err_add = err_add + 2'd1;
                end else begin
                    state_n   = BODY;
                    len_n     = hd_len;
                    addr_ok_n = hd_addr_ok;
                    seen_n    = 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            len_q      <= '0;
            addr_ok_q  <= 1'b0;
            flit_seen  <= '0;
            o_pkt_cnt  <= '0;
            o_flit_cnt <= '0;
            o_err_cnt  <= '0;
        end else begin
            state      <= state_n;
            len_q      <= len_n;
            addr_ok_q  <= addr_ok_n;
            flit_seen  <= seen_n;
            o_pkt_cnt  <= sat_add(o_pkt_cnt, {1'b0, pkt_add});
            o_flit_cnt <= sat_add(o_flit_cnt, {1'b0, pop});
            o_err_cnt  <= sat_add(o_err_cnt, err_add);
        end
    end

    assign o_busy = (state == BODY) || !empty;

endmodule

// File: doc/local_eject_sink.md
Name: local_eject_sink

Overview:
- Ejection-side consumer attached to a router's LOCAL output port. It is the counterpart of the traffic generator on the injection side.
- Accepts flits under on/off flow control and buffers them in a small FIFO.
- Drains the FIFO at a controllable rate and reassembles packets with an IDLE/BODY state machine.
- Checks flit ordering, destination address and packet length. Exposes saturating statistics counters for self-checking NoC benches.

Parameters:
- FLIT_W, 34, flit width. [33:32] type (00 HEAD, 01 BODY, 10 TAIL, 11 HEADTAIL); [31:0] payload.
- FIFO_DEPTH, 8, buffer entries; power of two, minimum 4.
- OFF_MARGIN, 2, free entries reserved to cover on/off round-trip latency.
- MY_X, 0, this node's x address (4 bits).
- MY_Y, 0, this node's y address (4 bits).
- CNT_W, 16, statistics counter width.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- i_flit  in  FLIT_W  flit from router LOCAL output
- i_upstream_req  in  1  i_flit valid this cycle
- o_on_off  out  1  1 = router may send; 0 = stop
- i_drain_en  in  1  consumer ready; allows one FIFO pop per cycle
- o_pkt_cnt  out  CNT_W  complete, error-free packets received
- o_flit_cnt  out  CNT_W  flits popped from the FIFO
- o_err_cnt  out  CNT_W  sequence, address and length errors
- o_overflow  out  1  sticky; a flit arrived while the FIFO was full
- o_busy  out  1  FSM is in BODY or the FIFO is non-empty

Behaviour:
- Reset (async assert, sync deassert handled by the existing reset tree):
  - FIFO empty, FSM IDLE.
  - All counters 0, o_overflow 0, o_busy 0, o_on_off 1.
  - Reset mid-packet discards the partial packet and all buffered flits without counting anything.
- Head payload layout: [31:28] dest x, [27:24] dest y, [23:16] packet length in flits including head (HEADTAIL length = 1), [15:0] packet id.
- Push:
  - When i_upstream_req=1 and the FIFO is not full, i_flit is written at the end of the cycle.
  - When the FIFO is full, the flit is dropped and o_overflow is set (stays set until reset).
  - o_on_off is ignored for acceptance; the sink never back-pressures other than via o_on_off.
- o_on_off is registered. Next value = 0 if occupancy after this cycle's push/pop > FIFO_DEPTH-1-OFF_MARGIN, else 1.
- Pop:
  - When i_drain_en=1 and the FIFO is non-empty, the head entry is consumed by the FSM and o_flit_cnt increments.
  - Push and pop in the same cycle leave occupancy unchanged; this is allowed when full (pop frees space first, so the push succeeds).
  - Pop-to-push bypass is not required: a flit is poppable at the earliest one cycle after its push.
- FSM operates on popped flits only:
  - IDLE + HEADTAIL: check dest==(MY_X,MY_Y) and length==1.
    - Pass: pkt_cnt++. Fail: err_cnt++.
    - Stay IDLE.
  - IDLE + HEAD:
    - Latch length and the addr_ok flag; set flit_seen=1.
    - A length field < 2 is a length error: err_cnt++ (once, at TAIL).
    - Go to BODY.
  - IDLE + BODY/TAIL: sequence error, err_cnt++, flit discarded, stay IDLE.
  - BODY + BODY: flit_seen++, stay BODY.
  - BODY + TAIL: flit_seen++ (including the tail). Go IDLE.
    - If addr_ok and flit_seen==length: pkt_cnt++.
    - Else: err_cnt++ (exactly one per packet regardless of the number of faults).
  - BODY + HEAD or HEADTAIL: sequence error. err_cnt++ for the abandoned packet, then process the new flit as from IDLE in the same cycle. A HEADTAIL can therefore cause err_cnt to advance by 2 in one cycle.
- Counters saturate at 2^CNT_W-1; they do not wrap. flit_seen is 8 bits and saturates at 255.
- o_busy is combinational from FSM state and FIFO empty.

Test Plan:
- Single HEADTAIL to (0,0), length 1, i_drain_en=1 -> after pop, pkt_cnt=1, flit_cnt=1, err_cnt=0, o_on_off held 1.
- 4-flit packet HEAD(len 4)/BODY/BODY/TAIL to (0,0), back-to-back -> pkt_cnt=1, flit_cnt=4, FSM returns to IDLE, o_busy=0 afterwards.
- i_drain_en=0, stream flits every cycle, FIFO_DEPTH=8, OFF_MARGIN=2 -> o_on_off falls the cycle after occupancy reaches 6. The 9th flit sets o_overflow=1, and occupancy stays 8.
- HEAD with dest (1,0) at node (0,0), then BODY and TAIL -> err_cnt=1, pkt_cnt=0. Stray TAIL in IDLE -> err_cnt=2.
- HEAD(len 3), BODY, then HEADTAIL(len 1, dest ok) -> err_cnt=1, pkt_cnt=1, FSM IDLE.
- Mid-packet with 3 flits buffered, pulse reset_n low asynchronously -> all outputs return to reset values immediately; a subsequent clean packet yields pkt_cnt=1.
